// File: rtl/serial_queue_ctrl.sv
// serial_queue_ctrl
//   Builds bytes from a bit-serial input and stores them in a small circular
//   FIFO. A byte is shifted in LSB first, one bit per rising edge of write_in.
//   The completed byte waits in a holding register until an enqueue command
//   commits it to the FIFO. A dequeue command pops the oldest byte onto
//   data_out.
//
// Ports
//   clock_1MHz  system clock; all logic runs on its rising edge
//   rst         synchronous active-high reset
//   data_in     serial data bit, taken on a write_in rising edge
//   write_in    bit strobe; each rising edge shifts in one bit
//   enqueue_in  commit command; each rising edge is one request
//   dequeue_in  pop command; each rising edge is one request
//   status_out  1 while ready to receive a new byte
//   data_out    last popped byte; holds until the next successful pop
//   count_out   FIFO occupancy, 0..DEPTH
//   full_out    count_out == DEPTH
//   empty_out   count_out == 0
module serial_queue_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                     clock_1MHz,
  input  logic                     rst,
  input  logic                     data_in,
  input  logic                     write_in,
  input  logic                     enqueue_in,
  input  logic                     dequeue_in,
  output logic                     status_out,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     full_out,
  output logic                     empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  logic          data_q;
  logic          write_q, write_qq;
  logic          enq_q, enq_qq;
  logic          deq_q, deq_qq;
  logic          write_edge, enq_edge, deq_edge;
  logic          is_full, is_empty;
  logic          push, pop;
  logic [7:0]    sr, sr_next, hold;
  logic [2:0]    bit_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic [7:0]    mem [DEPTH];

  // Edge detection on the registered inputs
  assign write_edge = write_q & ~write_qq;
  assign enq_edge   = enq_q & ~enq_qq;
  assign deq_edge   = deq_q & ~deq_qq;

  assign is_full  = (count_out == FULL_CNT);
  assign is_empty = (count_out == '0);

  // A full FIFO still accepts a push when a pop frees a slot in the same
  // cycle; the pop reads the pre-edge array, so the shared slot is safe.
  assign push = (state == HOLD) && enq_edge && (!is_full || deq_edge);
  assign pop  = deq_edge && !is_empty;

  assign sr_next = {data_q, sr[7:1]};

  always_comb begin
    count_next = count_out;
    case ({push, pop})
      2'b10:   count_next = count_out + 1'b1;
      2'b01:   count_next = count_out - 1'b1;
      default: count_next = count_out;
    endcase
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state      <= RECV;
      data_q     <= 1'b0;
      write_q    <= 1'b0;
      write_qq   <= 1'b0;
      enq_q      <= 1'b0;
      enq_qq     <= 1'b0;
      deq_q      <= 1'b0;
      deq_qq     <= 1'b0;
      sr         <= 8'h00;
      hold       <= 8'h00;
      bit_cnt    <= 3'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= 8'h00;
      status_out <= 1'b0;
      count_out  <= '0;
      full_out   <= 1'b0;
      empty_out  <= 1'b1;
    end else begin
      data_q   <= data_in;
      write_q  <= write_in;
      write_qq <= write_q;
      enq_q    <= enqueue_in;
      enq_qq   <= enq_q;
      deq_q    <= dequeue_in;
      deq_qq   <= deq_q;

      // Registered from the state, so it trails a state change by one edge
      status_out <= (state == RECV);

      count_out <= count_next;
      full_out  <= (count_next == FULL_CNT);
      empty_out <= (count_next == '0);

      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case (state)
        RECV: begin
          if (write_edge) begin
            sr <= sr_next;
            if (bit_cnt == 3'd7) begin
              hold    <= sr_next;
              bit_cnt <= 3'd0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // Write edges are dropped here; a rejected enqueue keeps hold.
          if (push) begin
            state <= RECV;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

  // Storage array is deliberately not cleared by reset
  always_ff @(posedge clock_1MHz) begin
    if (!rst && push) begin
      mem[wr_ptr] <= hold;
    end
  end

endmodule

// File: tb/tb_serial_queue_ctrl.sv
// Testbench for serial_queue_ctrl: table of operations with expected
// outputs, plus hand-written sequences for latency and corner cases.
`timescale 1ns/1ps
module tb_serial_queue_ctrl;

  localparam int OP_SEND   = 0;
  localparam int OP_ENQ    = 1;
  localparam int OP_DEQ    = 2;
  localparam int OP_ENQDEQ = 3;

  typedef struct {
    int         op;
    logic [7:0] arg;
    logic       status;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [7:0] data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       write_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       status_out;
  logic [7:0] data_out;
  logic [3:0] count_out;
  logic       full_out;
  logic       empty_out;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  serial_queue_ctrl #(.DEPTH(8)) dut (
    .clock_1MHz (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .data_out   (data_out),
    .count_out  (count_out),
    .full_out   (full_out),
    .empty_out  (empty_out)
  );

  always #500 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pulse_write(input logic b);
    data_in  = b;
    write_in = 1'b1;
    cyc(10);
    write_in = 1'b0;
    cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pulse_write(b[i]);
  endtask

  task automatic cmd(input logic enq, input logic deq);
    enqueue_in = enq;
    dequeue_in = deq;
    cyc(3);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    cyc(3);
  endtask

  function automatic vec_t mk(input int op, input logic [7:0] arg, input logic st,
                              input logic [3:0] c, input logic f, input logic e,
                              input logic [7:0] d);
    vec_t v;
    v.op = op; v.arg = arg; v.status = st; v.count = c;
    v.full = f; v.empty = e; v.data = d;
    return v;
  endfunction

  initial begin
    logic [7:0] b5a;
    logic [7:0] b3c;

    // Operation table, starting after the first 0xAA byte is enqueued
    vecs.push_back(mk(OP_DEQ, 8'h00, 1, 0, 0, 1, 8'hAA));
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(mk(OP_SEND, 8'(k), 0, 4'(k - 1), 0, (k == 1), 8'hAA));
      vecs.push_back(mk(OP_ENQ,  8'h00, 1, 4'(k), (k == 8), 0, 8'hAA));
    end
    vecs.push_back(mk(OP_SEND,   8'h09, 0, 8, 1, 0, 8'hAA));
    vecs.push_back(mk(OP_ENQ,    8'h00, 0, 8, 1, 0, 8'hAA));
    vecs.push_back(mk(OP_ENQDEQ, 8'h00, 1, 8, 1, 0, 8'h01));
    for (int j = 2; j <= 9; j++)
      vecs.push_back(mk(OP_DEQ, 8'h00, 1, 4'(9 - j), 0, (j == 9), 8'(j)));
    vecs.push_back(mk(OP_SEND, 8'h5C, 0, 0, 0, 1, 8'h09));
    vecs.push_back(mk(OP_ENQ,  8'h00, 1, 1, 0, 0, 8'h09));
    vecs.push_back(mk(OP_DEQ,  8'h00, 1, 0, 0, 1, 8'h5C));
    vecs.push_back(mk(OP_DEQ,  8'h00, 1, 0, 0, 1, 8'h5C));
    vecs.push_back(mk(OP_SEND, 8'h77, 0, 0, 0, 1, 8'h5C));
    vecs.push_back(mk(OP_ENQ,  8'h00, 1, 1, 0, 0, 8'h5C));
    vecs.push_back(mk(OP_DEQ,  8'h00, 1, 0, 0, 1, 8'h77));

    rst = 1'b1; data_in = 1'b0; write_in = 1'b0;
    enqueue_in = 1'b0; dequeue_in = 1'b0;

    // Reset sequence
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_status", i), status_out, 1'b0);
      chk($sformatf("rst%0d_empty", i), empty_out, 1'b1);
      chk($sformatf("rst%0d_full", i), full_out, 1'b0);
      chk($sformatf("rst%0d_count", i), count_out, 4'd0);
      chk($sformatf("rst%0d_data", i), data_out, 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_status", status_out, 1'b1);
    cyc(2);

    // 0xAA with exact status and count latency
    for (int i = 0; i < 7; i++) pulse_write(i[0]);
    data_in  = 1'b1;
    write_in = 1'b1;
    @(negedge clk); chk("aa_st_n",  status_out, 1'b1);
    @(negedge clk); chk("aa_st_n1", status_out, 1'b1);
    @(negedge clk); chk("aa_st_n2", status_out, 1'b0);
    cyc(7);
    write_in = 1'b0;
    cyc(10);
    enqueue_in = 1'b1;
    @(negedge clk); chk("aa_cnt_n",  count_out, 4'd0);
    @(negedge clk); chk("aa_cnt_n1", count_out, 4'd1);
    chk("aa_empty_n1", empty_out, 1'b0);
    @(negedge clk); chk("aa_st_enq", status_out, 1'b1);
    enqueue_in = 1'b0;
    cyc(3);

    // Table-driven operations
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_SEND:   send_byte(vecs[i].arg);
        OP_ENQ:    cmd(1'b1, 1'b0);
        OP_DEQ:    cmd(1'b0, 1'b1);
        default:   cmd(1'b1, 1'b1);
      endcase
      chk($sformatf("v%0d_status", i), status_out, vecs[i].status);
      chk($sformatf("v%0d_count", i),  count_out,  vecs[i].count);
      chk($sformatf("v%0d_full", i),   full_out,   vecs[i].full);
      chk($sformatf("v%0d_empty", i),  empty_out,  vecs[i].empty);
      chk($sformatf("v%0d_data", i),   data_out,   vecs[i].data);
    end

    // Ignored commands: writes in HOLD, enqueue in RECV
    send_byte(8'hC3);
    chk("ig_hold_st", status_out, 1'b0);
    for (int i = 0; i < 5; i++) pulse_write(i[0]);
    chk("ig_wr_st", status_out, 1'b0);
    chk("ig_wr_cnt", count_out, 4'd0);
    cmd(1'b1, 1'b0);
    chk("ig_c3_cnt", count_out, 4'd1);
    chk("ig_c3_st", status_out, 1'b1);
    b5a = 8'h5A;
    for (int i = 0; i < 3; i++) pulse_write(b5a[i]);
    cmd(1'b1, 1'b0);
    chk("ig_enq_cnt", count_out, 4'd1);
    chk("ig_enq_st", status_out, 1'b1);
    for (int i = 3; i < 8; i++) pulse_write(b5a[i]);
    chk("ig_5a_st", status_out, 1'b0);
    cmd(1'b1, 1'b0);
    chk("ig_5a_cnt", count_out, 4'd2);
    cmd(1'b0, 1'b1);
    chk("ig_pop_c3", data_out, 8'hC3);
    cmd(1'b0, 1'b1);
    chk("ig_pop_5a", data_out, 8'h5A);
    chk("ig_pop_cnt", count_out, 4'd0);

    // Reset mid-byte
    for (int i = 0; i < 4; i++) pulse_write(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_data", data_out, 8'h00);
    chk("mr_status", status_out, 1'b0);
    chk("mr_empty", empty_out, 1'b1);
    cyc(2);
    chk("mr_rel_st", status_out, 1'b1);
    b3c = 8'h3C;
    for (int i = 0; i < 4; i++) pulse_write(b3c[i]);
    chk("mr_part_st", status_out, 1'b1);
    for (int i = 4; i < 8; i++) pulse_write(b3c[i]);
    chk("mr_full_st", status_out, 1'b0);
    cmd(1'b1, 1'b0);
    chk("mr_cnt", count_out, 4'd1);
    cmd(1'b0, 1'b1);
    chk("mr_data_3c", data_out, 8'h3C);
    chk("mr_cnt0", count_out, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
